// File: rtl/if_id_fifo.sv
// if_id_fifo: instruction queue between fetch and decode.
// Holds up to DEPTH {pc, inst} pairs and presents the oldest one to ID with an
// explicit valid bit. A taken branch from EX empties the queue in one cycle.
// The ID outputs come only from registered state, so fetch-to-decode latency is
// one cycle and there is no combinational path from the IF inputs to ID.
module if_id_fifo #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic [INST_W-1:0] if_inst,
    output logic              if_ready,
    input  logic              ex_b_flag_i,
    input  logic              id_stall,
    output logic              id_valid,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
    logic [INST_W-1:0] inst_mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic full;
    logic empty;
    logic push;
    logic pop;

    // if_ready depends on the registered count only, so a same-cycle pop
    // never opens a slot for a push into a full queue.
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = if_valid && !full;
    assign pop   = !empty && !id_stall;

    // Next-state pointers and occupancy; a flush overrides push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (ex_b_flag_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Pointer and occupancy registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; wrong-path pushes during a flush are not written.
    always_ff @(posedge clk) begin
        if (push && !ex_b_flag_i && !rst) begin
            pc_mem_q[wr_ptr_q]   <= if_pc;
            inst_mem_q[wr_ptr_q] <= if_inst;
        end
    end

    assign if_ready = !full;
    assign id_valid = !empty;
    assign id_pc    = id_valid ? pc_mem_q[rd_ptr_q]   : '0;
    assign id_inst  = id_valid ? inst_mem_q[rd_ptr_q] : '0;
    assign count    = count_q;

endmodule

// File: tb/tb_if_id_fifo.sv
module tb_if_id_fifo;

    localparam int ADDR_W = 32;
    localparam int INST_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              if_valid = 1'b0;
    logic [ADDR_W-1:0] if_pc = '0;
    logic [INST_W-1:0] if_inst = '0;
    logic              if_ready;
    logic              ex_b_flag_i = 1'b0;
    logic              id_stall = 1'b0;
    logic              id_valid;
    logic [ADDR_W-1:0] id_pc;
    logic [INST_W-1:0] id_inst;
    logic [CNT_W-1:0]  count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } entry_t;

    entry_t            mq[$];
    logic [ADDR_W-1:0] pop_log[$];
    bit                chk_en = 1'b0;

    if_id_fifo #(
        .ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc),
        .if_inst(if_inst), .if_ready(if_ready), .ex_b_flag_i(ex_b_flag_i),
        .id_stall(id_stall), .id_valid(id_valid), .id_pc(id_pc),
        .id_inst(id_inst), .count(count)
    );

    always #5 clk = ~clk;

    // Reference model: a plain queue updated with the FIFO rules at each edge.
    always @(posedge clk) begin
        if (rst || ex_b_flag_i) begin
            mq.delete();
        end else begin
            bit do_push, do_pop;
            entry_t e;
            do_push = if_valid && (mq.size() < DEPTH);
            do_pop  = (mq.size() > 0) && !id_stall;
            if (do_pop) begin
                pop_log.push_back(mq[0].pc);
                void'(mq.pop_front());
            end
            if (do_push) begin
                e.pc   = if_pc;
                e.inst = if_inst;
                mq.push_back(e);
            end
        end
        if (rst) chk_en = 1'b1;
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            logic              e_valid;
            logic [ADDR_W-1:0] e_pc;
            logic [INST_W-1:0] e_inst;
            e_valid = (mq.size() > 0);
            e_pc    = e_valid ? mq[0].pc : '0;
            e_inst  = e_valid ? mq[0].inst : '0;
            checks++;
            if (id_valid !== e_valid || id_pc !== e_pc || id_inst !== e_inst ||
                count !== CNT_W'(mq.size()) || if_ready !== (mq.size() < DEPTH)) begin
                errors++;
                $display("FAIL model t=%0t got v=%0b pc=%h inst=%h cnt=%0d rdy=%0b exp v=%0b pc=%h inst=%h cnt=%0d rdy=%0b",
                         $time, id_valid, id_pc, id_inst, count, if_ready,
                         e_valid, e_pc, e_inst, mq.size(), (mq.size() < DEPTH));
            end
            checks++;
            assert (count <= CNT_W'(DEPTH)) else begin
                errors++;
                $display("FAIL count_bound got %0d max %0d", count, DEPTH);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_lit(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic push_stalled(input logic [ADDR_W-1:0] pc);
        if_valid = 1'b1;
        if_pc    = pc;
        if_inst  = 32'h1000_0000 | pc;
        tick();
    endtask

    initial begin
        // Reset with fetch active
        rst = 1'b1; if_valid = 1'b1; if_pc = 32'h500; if_inst = 32'h13;
        for (int i = 0; i < 2; i++) begin
            tick();
            expect_lit("rst_valid", {31'b0, id_valid}, 32'd0);
            expect_lit("rst_pc", id_pc, 32'd0);
            expect_lit("rst_inst", id_inst, 32'd0);
            expect_lit("rst_count", {29'b0, count}, 32'd0);
            expect_lit("rst_ready", {31'b0, if_ready}, 32'd1);
        end
        rst = 1'b0; if_valid = 1'b0;

        // One-cycle latency
        if_valid = 1'b1; if_pc = 32'h100; if_inst = 32'h0000_0013; id_stall = 1'b0;
        tick();
        if_valid = 1'b0;
        expect_lit("lat_valid", {31'b0, id_valid}, 32'd1);
        expect_lit("lat_pc", id_pc, 32'h100);
        expect_lit("lat_inst", id_inst, 32'h13);
        tick();
        expect_lit("lat_drain_valid", {31'b0, id_valid}, 32'd0);
        expect_lit("lat_drain_count", {29'b0, count}, 32'd0);

        // Fill under stall, refuse fifth push
        id_stall = 1'b1;
        for (int i = 0; i < 4; i++) push_stalled(ADDR_W'(4 * i));
        expect_lit("fill_count", {29'b0, count}, 32'd4);
        expect_lit("fill_ready", {31'b0, if_ready}, 32'd0);
        push_stalled(32'h10);
        if_valid = 1'b0;
        expect_lit("fill_refused_count", {29'b0, count}, 32'd4);
        expect_lit("fill_hold_pc", id_pc, 32'h0);
        id_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expect_lit("drain_order", id_pc, 32'(4 * i));
            tick();
        end
        expect_lit("drain_empty", {31'b0, id_valid}, 32'd0);

        // Full queue with simultaneous push attempt and pop
        id_stall = 1'b1;
        for (int i = 0; i < 4; i++) push_stalled(ADDR_W'(32'h40 + 4 * i));
        id_stall = 1'b0; if_valid = 1'b1; if_pc = 32'h50; if_inst = 32'h1000_0050;
        expect_lit("full_ready", {31'b0, if_ready}, 32'd0);
        tick();
        expect_lit("full_pop_count", {29'b0, count}, 32'd3);
        expect_lit("full_pop_pc", id_pc, 32'h44);
        tick();
        if_valid = 1'b0;
        expect_lit("full_pushpop_count", {29'b0, count}, 32'd3);
        expect_lit("full_pushpop_pc", id_pc, 32'h48);
        for (int i = 0; i < 3; i++) tick();
        expect_lit("full_drained", {29'b0, count}, 32'd0);

        // Flush with wrong-path push under stall
        id_stall = 1'b1;
        for (int i = 0; i < 3; i++) push_stalled(ADDR_W'(32'h60 + 4 * i));
        ex_b_flag_i = 1'b1; if_valid = 1'b1; if_pc = 32'h200; if_inst = 32'h1000_0200;
        tick();
        ex_b_flag_i = 1'b0; if_valid = 1'b0;
        expect_lit("flush_count", {29'b0, count}, 32'd0);
        expect_lit("flush_valid", {31'b0, id_valid}, 32'd0);
        expect_lit("flush_pc", id_pc, 32'd0);
        id_stall = 1'b0; if_valid = 1'b1; if_pc = 32'h300; if_inst = 32'h1000_0300;
        tick();
        if_valid = 1'b0;
        expect_lit("post_flush_valid", {31'b0, id_valid}, 32'd1);
        expect_lit("post_flush_pc", id_pc, 32'h300);
        tick();
        expect_lit("post_flush_empty", {29'b0, count}, 32'd0);

        // Wrap-around stream with single-cycle stall pulses
        pop_log.delete();
        begin
            int idx = 0;
            int guard = 0;
            bit last_stall = 1'b0;
            while (idx < 10 && guard < 200) begin
                if_valid = 1'b1;
                if_pc    = ADDR_W'(4 * idx);
                if_inst  = 32'h2000_0000 | (4 * idx);
                id_stall = last_stall ? 1'b0 : ($urandom_range(0, 2) == 0);
                last_stall = id_stall;
                if (if_ready) idx++;
                tick();
                guard++;
            end
            if_valid = 1'b0; id_stall = 1'b0;
            guard = 0;
            while (count != 0 && guard < 20) begin
                tick();
                guard++;
            end
            expect_lit("wrap_count_zero", {29'b0, count}, 32'd0);
            expect_lit("wrap_n_presented", 32'(pop_log.size()), 32'd10);
            for (int i = 0; i < 10 && i < pop_log.size(); i++)
                expect_lit("wrap_order", pop_log[i], 32'(4 * i));
        end

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
